// File: rtl/matrix_inverter_2x2_if.sv
// Valid/ready bundle for the 2x2 fixed-point matrix inverter.
// Matrices are row-major packed arrays: m[row][col].
interface matrix_inverter_2x2_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                            in_valid;
  logic                            in_ready;
  logic [1:0][1:0][DATA_WIDTH-1:0] mat;
  logic                            out_valid;
  logic                            out_ready;
  logic [1:0][1:0][DATA_WIDTH-1:0] inv;
  logic                            singular;

  modport master (
    output in_valid,
    output mat,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  inv,
    input  singular
  );

  modport slave (
    input  in_valid,
    input  mat,
    output in_ready,
    output out_valid,
    input  out_ready,
    output inv,
    output singular
  );
endinterface

// File: rtl/matrix_inverter_2x2.sv
// Sequential 2x2 fixed-point matrix inverter: det, restoring divide for 1/det, adjugate scale.
// Define MATRIX_INV_SATURATE_EN to clamp each inverse element instead of wrapping it.
module matrix_inverter_2x2 #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DECIMAL_BITS = 5
) (
  input logic                  clk,
  input logic                  reset,
  matrix_inverter_2x2_if.slave bus
);

  localparam int unsigned PW = 2 * DATA_WIDTH + 1;  // determinant product width
  localparam int unsigned QW = 2 * DATA_WIDTH;      // dividend / quotient width
  localparam int unsigned CW = $clog2(QW);
  localparam int unsigned AW = DATA_WIDTH + 1;      // adjugate element width
  localparam int unsigned SW = AW + DATA_WIDTH;     // adj * recip width

  localparam logic signed [PW-1:0] DetMax = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] DetMin = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] QuoMax  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [QW-1:0]         DivInit = QW'(1) << (2 * DECIMAL_BITS);

`ifdef MATRIX_INV_SATURATE_EN
  localparam logic signed [SW-1:0] ElemMax = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] ElemMin = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDet,
    StDiv,
    StScale,
    StOut
  } state_e;

  state_e                          state_q, state_d;
  logic [1:0][1:0][DATA_WIDTH-1:0] mat_q, mat_d;
  logic signed [PW-1:0]            prod_q, prod_d;
  logic [DATA_WIDTH-1:0]           divisor_q, divisor_d;
  logic                            det_neg_q, det_neg_d;
  logic [DATA_WIDTH-1:0]           rem_q, rem_d;
  logic [QW-1:0]                   dvd_q, dvd_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [1:0][1:0][DATA_WIDTH-1:0] inv_q, inv_d;
  logic                            singular_q, singular_d;

  logic signed [DATA_WIDTH-1:0] ea, eb, ec, ed;
  logic signed [AW-1:0]         adj00, adj01, adj10, adj11;
  logic signed [PW-1:0]         det_shift;
  logic signed [DATA_WIDTH-1:0] det_fx;
  logic [DATA_WIDTH:0]          rem_shift;
  logic                         rem_ge;
  logic [DATA_WIDTH-1:0]        quo_sat;
  logic signed [DATA_WIDTH-1:0] recip;

  assign ea = $signed(mat_q[0][0]);
  assign eb = $signed(mat_q[0][1]);
  assign ec = $signed(mat_q[1][0]);
  assign ed = $signed(mat_q[1][1]);

  // Widened by one bit so negating the most negative element cannot overflow.
  assign adj00 = AW'(ed);
  assign adj01 = -AW'(eb);
  assign adj10 = -AW'(ec);
  assign adj11 = AW'(ea);

  // Arithmetic shift rounds toward -inf, then clamp into the element range.
  assign det_shift = prod_q >>> DECIMAL_BITS;

  always_comb begin
    det_fx = DATA_WIDTH'(det_shift);
    if (det_shift > DetMax) begin
      det_fx = DATA_WIDTH'(DetMax);
    end else if (det_shift < DetMin) begin
      det_fx = DATA_WIDTH'(DetMin);
    end
  end

  // Restoring divide step: quotient bits shift into dvd_q as the dividend shifts out.
  assign rem_shift = {rem_q, dvd_q[QW-1]};
  assign rem_ge    = rem_shift >= {1'b0, divisor_q};

  assign quo_sat = (dvd_q > {{(QW-DATA_WIDTH){1'b0}}, QuoMax}) ? QuoMax : DATA_WIDTH'(dvd_q);
  assign recip   = det_neg_q ? -$signed(quo_sat) : $signed(quo_sat);

  function automatic logic [DATA_WIDTH-1:0] scale_elem(input logic signed [AW-1:0] adj,
                                                       input logic signed [DATA_WIDTH-1:0] rcp);
`ifdef MATRIX_INV_SATURATE_EN
    logic signed [SW-1:0] prod;
    prod = (SW'(adj) * SW'(rcp)) >>> DECIMAL_BITS;
    if (prod > ElemMax) begin
      return DATA_WIDTH'(ElemMax);
    end else if (prod < ElemMin) begin
      return DATA_WIDTH'(ElemMin);
    end
    return DATA_WIDTH'(prod);
`else
    return DATA_WIDTH'((SW'(adj) * SW'(rcp)) >>> DECIMAL_BITS);
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    prod_d     = prod_q;
    divisor_d  = divisor_q;
    det_neg_d  = det_neg_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    singular_d = singular_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mat_d   = bus.mat;
          state_d = StMul;
        end
      end
      StMul: begin
        prod_d  = PW'(ea) * PW'(ed) - PW'(eb) * PW'(ec);
        state_d = StDet;
      end
      StDet: begin
        if (det_fx == '0) begin
          singular_d = 1'b1;
          inv_d      = '0;
          state_d    = StOut;
        end else begin
          divisor_d = det_fx[DATA_WIDTH-1] ? DATA_WIDTH'(-det_fx) : DATA_WIDTH'(det_fx);
          det_neg_d = det_fx[DATA_WIDTH-1];
          rem_d     = '0;
          dvd_d     = DivInit;
          cnt_d     = '0;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        rem_d = rem_ge ? DATA_WIDTH'(rem_shift - {1'b0, divisor_q}) : DATA_WIDTH'(rem_shift);
        dvd_d = {dvd_q[QW-2:0], rem_ge};
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(QW - 1)) begin
          state_d = StScale;
        end
      end
      StScale: begin
        inv_d[0][0] = scale_elem(adj00, recip);
        inv_d[0][1] = scale_elem(adj01, recip);
        inv_d[1][0] = scale_elem(adj10, recip);
        inv_d[1][1] = scale_elem(adj11, recip);
        singular_d  = 1'b0;
        state_d     = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mat_q      <= '0;
      prod_q     <= '0;
      divisor_q  <= '0;
      det_neg_q  <= 1'b0;
      rem_q      <= '0;
      dvd_q      <= '0;
      cnt_q      <= '0;
      inv_q      <= '0;
      singular_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mat_q      <= mat_d;
      prod_q     <= prod_d;
      divisor_q  <= divisor_d;
      det_neg_q  <= det_neg_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      singular_q <= singular_d;
    end
  end

  // Gated by reset so the block never advertises readiness while being reset.
  assign bus.in_ready  = (state_q == StIdle) && !reset;
  assign bus.out_valid = (state_q == StOut);
  assign bus.inv       = inv_q;
  assign bus.singular  = singular_q;

endmodule

// File: tb/tb_matrix_inverter_2x2.sv
// Directed + scoreboard bench for matrix_inverter_2x2; honours MATRIX_INV_SATURATE_EN.
module tb_matrix_inverter_2x2;
  localparam int unsigned DW = 16;
  localparam int unsigned DB = 5;

  typedef logic [1:0][1:0][DW-1:0] mat_t;
  typedef struct {
    mat_t inv;
    logic sing;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  matrix_inverter_2x2_if #(.DATA_WIDTH(DW)) bus ();

  matrix_inverter_2x2 #(
    .DATA_WIDTH  (DW),
    .DECIMAL_BITS(DB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t mkm(input int a, input int b, input int c, input int d);
    mat_t m;
    m[0][0] = DW'(a);
    m[0][1] = DW'(b);
    m[1][0] = DW'(c);
    m[1][1] = DW'(d);
    return m;
  endfunction

  function automatic exp_t mk(input int i00, input int i01, input int i10, input int i11,
                              input logic sing, input int lat);
    exp_t e;
    e.inv  = mkm(i00, i01, i10, i11);
    e.sing = sing;
    e.lat  = lat;
    return e;
  endfunction

  // Integer reference: det, 1/det by integer division, adjugate scale.
  function automatic exp_t model(input mat_t m);
    exp_t   e;
    longint a, b, c, d, p, det, q, r, v;
    longint adj[4];
    a = longint'($signed(m[0][0]));
    b = longint'($signed(m[0][1]));
    c = longint'($signed(m[1][0]));
    d = longint'($signed(m[1][1]));
    p = a * d - b * c;
    det = p >>> DB;
    if (det > 32767) det = 32767;
    if (det < -32768) det = -32768;
    e.inv = '0;
    if (det == 0) begin
      e.sing = 1'b1;
      e.lat  = 2;
      return e;
    end
    q = (longint'(1) << (2 * DB)) / ((det < 0) ? -det : det);
    if (q > 32767) q = 32767;
    r = (det < 0) ? -q : q;
    adj[0] = d;
    adj[1] = -b;
    adj[2] = -c;
    adj[3] = a;
    for (int k = 0; k < 4; k++) begin
      v = (adj[k] * r) >>> DB;
`ifdef MATRIX_INV_SATURATE_EN
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`endif
      e.inv[k/2][k%2] = v[DW-1:0];
    end
    e.sing = 1'b0;
    e.lat  = 2 * DW + 3;
    return e;
  endfunction

  // One job; hold > 0 stalls the consumer for that many cycles and drives junk in_valid meanwhile.
  task automatic run_job(input mat_t m, input exp_t e, input int hold);
    int   n;
    exp_t x;
    mat_t held;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    sb.push_back(e);
    bus.mat       = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = (hold != 0);
    if (hold != 0) bus.mat = mkm(-1, 7, 7, -1);
    chk("in_ready_busy", bus.in_ready, 0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    x = sb.pop_front();
    chk("out_valid", bus.out_valid, 1);
    chk("latency", 64'(n), 64'(x.lat));
    chk("singular", bus.singular, x.sing);
    chk("inv", bus.inv, x.inv);
    if (hold != 0) begin
      held = bus.inv;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_inv", bus.inv, held);
        chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_fall", bus.out_valid, 0);
    chk("in_ready_rise", bus.in_ready, 1);
  endtask

  initial begin
    int   seen;
    mat_t m;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mat       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_inv", bus.inv, 0);
    chk("rst_singular", bus.singular, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    run_job(mkm(32, 0, 0, 32), mk(32, 0, 0, 32, 1'b0, 35), 0);
    run_job(mkm(64, 0, 0, 64), mk(16, 0, 0, 16, 1'b0, 35), 0);
    run_job(mkm(0, 32, 32, 0), mk(0, 32, 32, 0, 1'b0, 35), 0);
    run_job(mkm(32, 64, 16, 32), mk(0, 0, 0, 0, 1'b1, 2), 0);
    run_job(mkm(1, 0, 0, 1), mk(0, 0, 0, 0, 1'b1, 2), 0);
`ifdef MATRIX_INV_SATURATE_EN
    run_job(mkm(4000, 3992, 4008, 4000), mk(32767, -32768, -32768, 32767, 1'b0, 35), 0);
    run_job(mkm(32, -32768, 0, 32), mk(32, 32767, 0, 32, 1'b0, 35), 0);
`else
    run_job(mkm(4000, 3992, 4008, 4000), mk('hFA00, 'h0680, 'h0580, 'hFA00, 1'b0, 35), 0);
    run_job(mkm(32, -32768, 0, 32), mk(32, 'h8000, 0, 32, 1'b0, 35), 0);
`endif

    // Consumer stall with junk on the input side while busy.
    run_job(mkm(64, 0, 0, 64), mk(16, 0, 0, 16, 1'b0, 35), 10);

    // Reset ten cycles into the divide.
    @(negedge clk);
    bus.mat       = mkm(32, 0, 0, 32);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_inv", bus.inv, 0);
    reset = 1'b0;
    #1;
    chk("midrst_idle", bus.in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_stale", 64'(seen), 0);
    run_job(mkm(32, 0, 0, 32), mk(32, 0, 0, 32, 1'b0, 35), 0);

    // Scoreboard against the integer model on pseudo-random small matrices.
    for (int i = 0; i < 6; i++) begin
      m = mkm(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      run_job(m, model(m), 0);
    end

    chk("sb_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
